// File: rtl/nmea_zda_decoder_if.sv
// Byte stream carrying received UART characters into the ZDA decoder.
//   in_tdata  : received character
//   in_tvalid : one-cycle strobe, in_tdata valid
// master drives the stream, slave (the decoder) consumes it.
interface nmea_zda_decoder_if;
    logic [7:0] in_tdata;
    logic       in_tvalid;

    modport master (output in_tdata, output in_tvalid);
    modport slave  (input  in_tdata, input  in_tvalid);
endinterface

// File: rtl/nmea_zda_decoder.sv
// Streaming NMEA ZDA decoder. Parses "$ttZDA,hhmmss[.ss],dd,mm,yyyy,zh,zm*CC",
// checks field formats, ranges and the XOR checksum, then commits the decoded
// time/date atomically with a one-cycle time_valid pulse.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_bus          : character stream (in_tdata / in_tvalid)
//   time_valid      : one-cycle pulse, new time committed
//   hour..year      : last committed time/date (binary)
//   csum_err_cnt    : saturating count of checksum failures
//   fmt_err_cnt     : saturating count of format/range/length failures
//   busy            : sentence parse in progress
module nmea_zda_decoder #(
    parameter bit ACCEPT_ANY_TALKER = 1'b1,
    parameter bit CHECK_CSUM        = 1'b1,
    parameter int MAX_LEN           = 82,
    parameter int ERR_CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nmea_zda_decoder_if.slave    in_bus,
    output logic                 time_valid,
    output logic [4:0]           hour,
    output logic [5:0]           minute,
    output logic [5:0]           second,
    output logic [6:0]           centisec,
    output logic [4:0]           day,
    output logic [3:0]           month,
    output logic [11:0]          year,
    output logic [ERR_CNT_W-1:0] csum_err_cnt,
    output logic [ERR_CNT_W-1:0] fmt_err_cnt,
    output logic                 busy
);
    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, HDR, FIELDS, CSUM_HI, CSUM_LO} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n, len_inc;
    logic [7:0]       xsum, xsum_n;
    logic [2:0]       fld, fld_n;
    logic [2:0]       dcnt, dcnt_n;
    logic             dot, dot_n;
    logic [1:0]       frac, frac_n;
    logic [3:0]       csum_hi, csum_hi_n;
    logic [4:0]       sh_hour, sh_hour_n;
    logic [5:0]       sh_minute, sh_minute_n;
    logic [5:0]       sh_second, sh_second_n;
    logic [6:0]       sh_centisec, sh_centisec_n;
    logic [4:0]       sh_day, sh_day_n;
    logic [3:0]       sh_month, sh_month_n;
    logic [11:0]      sh_year, sh_year_n;
    logic             fmt_fail, csum_fail, commit, bad;
    logic [7:0]       ch;
    logic [3:0]       dig;

    assign ch   = in_bus.in_tdata;
    assign dig  = ch[3:0];
    assign busy = (state != IDLE);

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_digit(c) || ((c >= "A") && (c <= "F")) || ((c >= "a") && (c <= "f"));
    endfunction

    // 'A'/'a' have low nibble 1, so letters map to nibble + 9.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= "9") ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    // Wide multiply-accumulate; callers truncate to their port width.
    function automatic logic [15:0] mac10(input logic [15:0] acc, input logic [3:0] d);
        return acc * 16'd10 + {12'd0, d};
    endfunction

    function automatic logic hdr_ok(input logic [2:0] pos, input logic [7:0] c);
        case (pos)
            3'd0:    return ACCEPT_ANY_TALKER ? ((c >= "A") && (c <= "Z")) : (c == "G");
            3'd1:    return ACCEPT_ANY_TALKER ? ((c >= "A") && (c <= "Z")) : (c == "P");
            3'd2:    return c == "Z";
            3'd3:    return c == "D";
            3'd4:    return c == "A";
            3'd5:    return c == ",";
            default: return 1'b0;
        endcase
    endfunction

    // Integer digits required in each checked field (time, day, month, year).
    function automatic logic [2:0] field_need(input logic [2:0] f);
        case (f)
            3'd0:    return 3'd6;
            3'd1:    return 3'd2;
            3'd2:    return 3'd2;
            3'd3:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic range_ok(input logic [4:0] h, input logic [5:0] mi,
                                      input logic [5:0] s, input logic [6:0] cs,
                                      input logic [4:0] d, input logic [3:0] mo);
        return (h <= 5'd23) && (mi <= 6'd59) && (s <= 6'd60) && (cs <= 7'd99) &&
               (d != 5'd0) && (mo != 4'd0) && (mo <= 4'd12);
    endfunction

    always_comb begin
        state_n       = state;
        len_n         = len;
        xsum_n        = xsum;
        fld_n         = fld;
        dcnt_n        = dcnt;
        dot_n         = dot;
        frac_n        = frac;
        csum_hi_n     = csum_hi;
        sh_hour_n     = sh_hour;
        sh_minute_n   = sh_minute;
        sh_second_n   = sh_second;
        sh_centisec_n = sh_centisec;
        sh_day_n      = sh_day;
        sh_month_n    = sh_month;
        sh_year_n     = sh_year;
        fmt_fail      = 1'b0;
        csum_fail     = 1'b0;
        commit        = 1'b0;
        bad           = 1'b0;
        len_inc       = len + LEN_W'(1);
        if (in_bus.in_tvalid) begin
            if (ch == "$") begin
                // Start of sentence restarts everything; an interrupted body is a format error.
                state_n       = HDR;
                len_n         = '0;
                xsum_n        = '0;
                fld_n         = '0;
                dcnt_n        = '0;
                dot_n         = 1'b0;
                frac_n        = '0;
                csum_hi_n     = '0;
                sh_hour_n     = '0;
                sh_minute_n   = '0;
                sh_second_n   = '0;
                sh_centisec_n = '0;
                sh_day_n      = '0;
                sh_month_n    = '0;
                sh_year_n     = '0;
                fmt_fail      = (state == FIELDS) || (state == CSUM_HI) || (state == CSUM_LO);
            end else if (state != IDLE) begin
                len_n = len_inc;
                if (len_inc > MAX_LEN_L) begin
                    fmt_fail = (state != HDR);
                    state_n  = IDLE;
                end else begin
                    case (state)
                        HDR: begin
                            xsum_n = xsum ^ ch;
                            // Foreign talkers/sentence types are dropped silently.
                            if (!hdr_ok(len[2:0], ch))  state_n = IDLE;
                            else if (len[2:0] == 3'd5)  state_n = FIELDS;
                        end
                        FIELDS: begin
                            if (ch == "*") begin
                                if (fld == 3'd5) state_n = CSUM_HI;
                                else             bad = 1'b1;
                            end else begin
                                xsum_n = xsum ^ ch;
                                if (ch == ",") begin
                                    if (fld == 3'd5 || (fld < 3'd4 && dcnt != field_need(fld))) begin
                                        bad = 1'b1;
                                    end else begin
                                        fld_n  = fld + 3'd1;
                                        dcnt_n = '0;
                                    end
                                end else if (fld >= 3'd4) begin
                                    // Local zone fields: content ignored.
                                end else if (fld == 3'd0 && ch == ".") begin
                                    if (dot || dcnt != 3'd6) bad = 1'b1;
                                    else                     dot_n = 1'b1;
                                end else if (!is_digit(ch)) begin
                                    bad = 1'b1;
                                end else if (fld == 3'd0 && dot) begin
                                    // Fraction is weighted by position so a lone digit means tenths.
                                    if (frac == 2'd2) begin
                                        bad = 1'b1;
                                    end else begin
                                        frac_n = frac + 2'd1;
                                        if (frac == 2'd0) sh_centisec_n = 7'(mac10({12'd0, dig}, 4'd0));
                                        else              sh_centisec_n = sh_centisec + {3'd0, dig};
                                    end
                                end else if (dcnt == field_need(fld)) begin
                                    bad = 1'b1;
                                end else begin
                                    dcnt_n = dcnt + 3'd1;
                                    case (fld)
                                        3'd0: begin
                                            if (dcnt < 3'd2)      sh_hour_n   = 5'(mac10({11'd0, sh_hour}, dig));
                                            else if (dcnt < 3'd4) sh_minute_n = 6'(mac10({10'd0, sh_minute}, dig));
                                            else                  sh_second_n = 6'(mac10({10'd0, sh_second}, dig));
                                        end
                                        3'd1:    sh_day_n   = 5'(mac10({11'd0, sh_day}, dig));
                                        3'd2:    sh_month_n = 4'(mac10({12'd0, sh_month}, dig));
                                        default: sh_year_n  = 12'(mac10({4'd0, sh_year}, dig));
                                    endcase
                                end
                            end
                        end
                        CSUM_HI: begin
                            if (!is_hex(ch)) begin
                                bad = 1'b1;
                            end else begin
                                csum_hi_n = hex_val(ch);
                                state_n   = CSUM_LO;
                            end
                        end
                        CSUM_LO: begin
                            state_n = IDLE;
                            if (!is_hex(ch) || !range_ok(sh_hour, sh_minute, sh_second,
                                                         sh_centisec, sh_day, sh_month))
                                fmt_fail = 1'b1;
                            else if (CHECK_CSUM && ({csum_hi, hex_val(ch)} != xsum))
                                csum_fail = 1'b1;
                            else
                                commit = 1'b1;
                        end
                        default: ;
                    endcase
                    if (bad) begin
                        fmt_fail = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
        end
    end

    // Control and committed outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            time_valid   <= 1'b0;
            hour         <= '0;
            minute       <= '0;
            second       <= '0;
            centisec     <= '0;
            day          <= '0;
            month        <= '0;
            year         <= '0;
            csum_err_cnt <= '0;
            fmt_err_cnt  <= '0;
        end else begin
            state      <= state_n;
            time_valid <= commit;
            if (commit) begin
                hour     <= sh_hour;
                minute   <= sh_minute;
                second   <= sh_second;
                centisec <= sh_centisec;
                day      <= sh_day;
                month    <= sh_month;
                year     <= sh_year;
            end
            if (csum_fail && csum_err_cnt != '1) csum_err_cnt <= csum_err_cnt + ERR_CNT_W'(1);
            if (fmt_fail && fmt_err_cnt != '1)   fmt_err_cnt  <= fmt_err_cnt + ERR_CNT_W'(1);
        end
    end

    // Parse context and shadow registers; all re-initialised on every '$'
    always_ff @(posedge clk) begin
        len         <= len_n;
        xsum        <= xsum_n;
        fld         <= fld_n;
        dcnt        <= dcnt_n;
        dot         <= dot_n;
        frac        <= frac_n;
        csum_hi     <= csum_hi_n;
        sh_hour     <= sh_hour_n;
        sh_minute   <= sh_minute_n;
        sh_second   <= sh_second_n;
        sh_centisec <= sh_centisec_n;
        sh_day      <= sh_day_n;
        sh_month    <= sh_month_n;
        sh_year     <= sh_year_n;
    end
endmodule

// File: tb/tb_nmea_zda_decoder.sv
// Scoreboard testbench for nmea_zda_decoder: directed sentences plus random
// (possibly corrupted) sentences, checked against a string-level reference model.
module tb_nmea_zda_decoder;
    localparam bit ACC  = 1'b1;
    localparam bit CHK  = 1'b1;
    localparam int MAXL = 82;
    localparam int EW   = 16;

    localparam int K_OK = 1, K_CSUM = 2, K_FMT = 3;

    typedef struct {
        int kind; int due; int c; int f;
        int h; int mi; int se; int cs; int d; int mo; int y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic time_valid, busy;
    logic [4:0] hour; logic [5:0] minute; logic [5:0] second; logic [6:0] centisec;
    logic [4:0] day;  logic [3:0] month;  logic [11:0] year;
    logic [EW-1:0] csum_err_cnt, fmt_err_cnt;

    nmea_zda_decoder_if bus ();

    nmea_zda_decoder #(.ACCEPT_ANY_TALKER(ACC), .CHECK_CSUM(CHK), .MAX_LEN(MAXL), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .in_bus(bus.slave), .time_valid(time_valid),
        .hour(hour), .minute(minute), .second(second), .centisec(centisec),
        .day(day), .month(month), .year(year),
        .csum_err_cnt(csum_err_cnt), .fmt_err_cnt(fmt_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    exp_t sb[$];

    // Model state
    byte unsigned mbuf[$];
    bit m_active;
    int exp_c, exp_f;
    int l_h, l_mi, l_se, l_cs, l_d, l_mo, l_y;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_dig(input byte unsigned c);
        return c >= "0" && c <= "9";
    endfunction
    function automatic bit is_hx(input byte unsigned c);
        return is_dig(c) || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction
    function automatic int hexv(input byte unsigned c);
        if (is_dig(c)) return c - "0";
        if (c >= "a") return c - "a" + 10;
        return c - "A" + 10;
    endfunction
    function automatic int dv(input int i);
        return mbuf[i] - "0";
    endfunction

    // Is field k (start st, length ln) a valid prefix / complete value?
    function automatic bit field_ok(input int k, input int st, input int ln, input bit closed);
        int need;
        need = (k == 0) ? 6 : (k == 3) ? 4 : 2;
        for (int j = 0; j < ln; j++) begin
            if (k == 0) begin
                if (j == 6) begin
                    if (mbuf[st+j] != ".") return 0;
                end else if (j > 8 || !is_dig(mbuf[st+j])) return 0;
            end else if (j >= need || !is_dig(mbuf[st+j])) return 0;
        end
        if (closed && ln < need) return 0;
        return 1;
    endfunction

    // Judge the text received since '$' from scratch.
    typedef enum int {V_CONT, V_DROP, V_FMT, V_CSUM, V_OK} verdict_t;
    function automatic verdict_t verdict(output int h, output int mi, output int se, output int cs,
                                         output int d, output int mo, output int y);
        string hz = "ZDA,";
        int n, star, end_f, nf, x, rx, fl0;
        int fs[6];
        int fl[6];
        h = 0; mi = 0; se = 0; cs = 0; d = 0; mo = 0; y = 0;
        n = mbuf.size();
        for (int i = 0; i < n && i < 6; i++) begin
            if (i < 2) begin
                if (ACC ? !(mbuf[i] >= "A" && mbuf[i] <= "Z") : mbuf[i] != ((i == 0) ? "G" : "P"))
                    return V_DROP;
            end else if (mbuf[i] != hz[i-2]) return V_DROP;
        end
        if (n < 6) return V_CONT;
        if (n > MAXL) return V_FMT;
        star = -1;
        for (int i = 6; i < n; i++) if (mbuf[i] == "*") begin star = i; break; end
        end_f = (star < 0) ? n : star;
        nf = 1; fs[0] = 6;
        for (int i = 6; i < end_f; i++) begin
            if (mbuf[i] == ",") begin
                fl[nf-1] = i - fs[nf-1];
                if (nf == 6) return V_FMT;
                fs[nf] = i + 1;
                nf++;
            end
        end
        fl[nf-1] = end_f - fs[nf-1];
        for (int k = 0; k < nf && k < 4; k++)
            if (!field_ok(k, fs[k], fl[k], (k < nf - 1) || (star >= 0))) return V_FMT;
        if (star < 0) return V_CONT;
        if (nf != 6) return V_FMT;
        for (int i = star + 1; i < n; i++) if (!is_hx(mbuf[i])) return V_FMT;
        if (n - star - 1 < 2) return V_CONT;
        h  = (dv(6) * 10 + dv(7)) % 32;
        mi = (dv(8) * 10 + dv(9)) % 64;
        se = (dv(10) * 10 + dv(11)) % 64;
        fl0 = fl[0];
        cs = ((fl0 >= 8) ? dv(13) * 10 : 0) + ((fl0 >= 9) ? dv(14) : 0);
        d  = (dv(fs[1]) * 10 + dv(fs[1] + 1)) % 32;
        mo = (dv(fs[2]) * 10 + dv(fs[2] + 1)) % 16;
        y  = (((dv(fs[3]) * 10 + dv(fs[3] + 1)) * 10 + dv(fs[3] + 2)) * 10 + dv(fs[3] + 3)) % 4096;
        if (h > 23 || mi > 59 || se > 60 || cs > 99 || d < 1 || d > 31 || mo < 1 || mo > 12)
            return V_FMT;
        x = 0;
        for (int i = 0; i < star; i++) x = x ^ mbuf[i];
        rx = hexv(mbuf[star+1]) * 16 + hexv(mbuf[star+2]);
        if (CHK && rx != x) return V_CSUM;
        return V_OK;
    endfunction

    task automatic push_exp(input int kind);
        exp_t e;
        if (kind == K_CSUM) exp_c++;
        if (kind == K_FMT)  exp_f++;
        e.kind = kind; e.due = cyc + 1; e.c = exp_c; e.f = exp_f;
        e.h = l_h; e.mi = l_mi; e.se = l_se; e.cs = l_cs; e.d = l_d; e.mo = l_mo; e.y = l_y;
        sb.push_back(e);
    endtask

    task automatic model_step(input byte unsigned c);
        verdict_t v;
        int h, mi, se, cs, d, mo, y;
        if (c == "$") begin
            if (m_active && mbuf.size() >= 6) push_exp(K_FMT);
            mbuf.delete();
            m_active = 1;
        end else if (m_active) begin
            mbuf.push_back(c);
            v = verdict(h, mi, se, cs, d, mo, y);
            case (v)
                V_DROP: m_active = 0;
                V_FMT:  begin push_exp(K_FMT);  m_active = 0; end
                V_CSUM: begin push_exp(K_CSUM); m_active = 0; end
                V_OK: begin
                    l_h = h; l_mi = mi; l_se = se; l_cs = cs; l_d = d; l_mo = mo; l_y = y;
                    push_exp(K_OK);
                    m_active = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_active = 0;
        exp_c = 0; exp_f = 0;
        l_h = 0; l_mi = 0; l_se = 0; l_cs = 0; l_d = 0; l_mo = 0; l_y = 0;
    endtask

    task automatic send_byte(input byte unsigned c);
        @(posedge clk); #1;
        check("busy", int'(busy), int'(m_active));
        bus.in_tdata  = c;
        bus.in_tvalid = 1'b1;
        model_step(c);
    endtask

    task automatic gap(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            check("busy", int'(busy), int'(m_active));
            bus.in_tvalid = 1'b0;
            bus.in_tdata  = 8'h00;
        end
    endtask

    task automatic send_str(input string s, input bit jitter);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (jitter && $urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end
        gap(1);
    endtask

    task automatic check_zero_outputs();
        check("rst_time_valid", int'(time_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_hour", int'(hour), 0);
        check("rst_minute", int'(minute), 0);
        check("rst_second", int'(second), 0);
        check("rst_centisec", int'(centisec), 0);
        check("rst_day", int'(day), 0);
        check("rst_month", int'(month), 0);
        check("rst_year", int'(year), 0);
        check("rst_csum_cnt", int'(csum_err_cnt), 0);
        check("rst_fmt_cnt", int'(fmt_err_cnt), 0);
    endtask

    task automatic gen_sentence();
        string s, body, ns;
        int h, mi, se, d, mo, y, fr;
        byte unsigned x, ta, tb2;
        ns  = "0123456789,.*$AZ#a";
        ta  = 8'("A" + $urandom_range(0, 25));
        tb2 = ($urandom_range(0, 15) == 0) ? 8'("a") : 8'("A" + $urandom_range(0, 25));
        h  = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 99) : $urandom_range(0, 23);
        mi = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 99) : $urandom_range(0, 59);
        se = ($urandom_range(0, 9) == 0) ? $urandom_range(61, 99) : $urandom_range(0, 60);
        d  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(1, 31);
        mo = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 99) : $urandom_range(1, 12);
        y  = ($urandom_range(0, 9) == 0) ? $urandom_range(4096, 9999) : $urandom_range(0, 4095);
        body = $sformatf("%c%cZDA,%02d%02d%02d", ta, tb2, h, mi, se);
        fr = $urandom_range(0, 3);
        if (fr >= 1) body = {body, "."};
        if (fr >= 2) body = {body, $sformatf("%0d", $urandom_range(0, 9))};
        if (fr == 3) body = {body, $sformatf("%0d", $urandom_range(0, 9))};
        body = {body, $sformatf(",%02d,%02d,%04d,%02d,%02d", d, mo, y,
                                $urandom_range(0, 12), $urandom_range(0, 59))};
        x = 8'h00;
        for (int i = 0; i < body.len(); i++) x = x ^ body[i];
        if ($urandom_range(0, 7) == 0) x = x ^ 8'($urandom_range(1, 255));
        s = {"$", body, "*", ($urandom_range(0, 1) != 0) ? $sformatf("%02X", x) : $sformatf("%02x", x)};
        if ($urandom_range(0, 7) == 0) s.putc($urandom_range(1, s.len() - 1), ns[$urandom_range(0, ns.len() - 1)]);
        if ($urandom_range(0, 9) == 0) s = s.substr(0, $urandom_range(1, s.len() - 2));
        if ($urandom_range(0, 1) != 0) s = {s, "\015\012"};
        send_str(s, 1'b1);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard.
    exp_t me;
    int mon_c = 0, mon_f = 0, act_kind;
    always @(negedge clk) begin
        if (rst) begin
            mon_c = 0;
            mon_f = 0;
        end else begin
            if (time_valid || int'(csum_err_cnt) != mon_c || int'(fmt_err_cnt) != mon_f) begin
                act_kind = time_valid ? K_OK : (int'(csum_err_cnt) != mon_c) ? K_CSUM : K_FMT;
                if (sb.size() == 0) begin
                    check("unexpected_event_kind", act_kind, 0);
                    mon_c = int'(csum_err_cnt);
                    mon_f = int'(fmt_err_cnt);
                end else begin
                    me = sb.pop_front();
                    check("event_kind", act_kind, me.kind);
                    check("event_latency", cyc, me.due);
                    check("csum_err_cnt", int'(csum_err_cnt), me.c);
                    check("fmt_err_cnt", int'(fmt_err_cnt), me.f);
                    check("hour", int'(hour), me.h);
                    check("minute", int'(minute), me.mi);
                    check("second", int'(second), me.se);
                    check("centisec", int'(centisec), me.cs);
                    check("day", int'(day), me.d);
                    check("month", int'(month), me.mo);
                    check("year", int'(year), me.y);
                    mon_c = me.c;
                    mon_f = me.f;
                end
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                me = sb.pop_front();
                check("missing_event_kind", 0, me.kind);
                mon_c = me.c;
                mon_f = me.f;
            end
        end
    end

    initial begin
        string pad;
        rst = 1'b1;
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();
        rst = 1'b0;

        send_str("$GPZDA,210935.00,13,11,2020,00,00*68\015\012", 1'b0);
        send_str("$GNZDA,210935.00,13,11,2020,00,00*76", 1'b0);
        send_str("$GPZDA,210935.00,13,11,2020,00,00*69", 1'b0);
        send_str("$GPZDA,250935.00,13,11,2020,00,00*6C", 1'b0);
        send_str("$GPZDA,,,,,,*..", 1'b0);
        send_str("$GPZDA,2109", 1'b0);
        send_str("$GPZDA,123456.7,01,02,0003,00,00*45", 1'b1);
        pad = "$GPZDA,210935.00,13,11,2020,00,00";
        for (int i = 0; i < 67; i++) pad = {pad, "0"};
        send_str(pad, 1'b0);

        // Reset in the middle of the month field, then a clean sentence.
        send_str("$GPZDA,210935.00,13,1", 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs();
        rst = 1'b0;
        send_str("$GPZDA,210935.00,13,11,2020,00,00*68", 1'b0);

        for (int n = 0; n < 300; n++) begin
            gen_sentence();
            if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 4));
        end

        gap(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
